// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state encoding, RV32I opcode constants and state-register macro for cpu_ctrl_fsm
`ifndef CPU_CTRL_DFF_AR
`define CPU_CTRL_DFF_AR(clk_s, rst_s, q_s, d_s, rv_s) \
  always_ff @(posedge clk_s or posedge rst_s) begin \
    if (rst_s) q_s <= rv_s; \
    else       q_s <= d_s; \
  end
`endif

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // True for the opcodes this controller knows how to sequence through EXEC
  function automatic logic is_exec_opcode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_LUI,
      OP_BRANCH, OP_JAL, OP_JALR: is_exec_opcode = 1'b1;
      default:                    is_exec_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enable-driven up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count enabled cycles, holding once every bit is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle RV32I control sequencer with retired-instruction counter
module cpu_ctrl_fsm #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_load,
  output logic             ir_load,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  import cpu_ctrl_pkg::*;

  state_t r_state;
  state_t w_next_state;
  logic   r_illegal;
  logic   w_set_illegal;

  // State register; reset drops straight to IDLE so strobes clear without a clock
  `CPU_CTRL_DFF_AR(clk, rst, r_state, w_next_state, S_IDLE)

  // Sticky undecodable-opcode flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  // Next state and strobes; strobes are a function of state plus branch_cond/mem_ready
  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    pc_en         = 1'b0;
    pc_load       = 1'b0;
    ir_load       = 1'b0;
    reg_we        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    halted        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        ir_load      = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          w_next_state = S_HALT;
        end else if (!is_exec_opcode(opcode)) begin
          w_set_illegal = 1'b1;
          w_next_state  = S_HALT;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_OP, OP_OPIMM, OP_LUI: w_next_state = S_WB;
          OP_LOAD, OP_STORE:       w_next_state = S_MEM;
          OP_BRANCH: begin
            pc_en        = 1'b1;
            pc_load      = branch_cond;
            w_next_state = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            reg_we       = 1'b1;
            pc_en        = 1'b1;
            pc_load      = 1'b1;
            w_next_state = S_FETCH;
          end
          // DECODE only forwards known opcodes, so this arm means opcode broke its stability promise
          default: w_next_state = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_en        = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we       = 1'b1;
        pc_en        = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign illegal = r_illegal;

  sat_counter #(
    .W(CNT_W)
  ) u_retire_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_en (pc_en),
    .o_cnt(retired_cnt)
  );

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - table-driven bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

  localparam logic [2:0] ST_I = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3;
  localparam logic [2:0] ST_M = 3'd4, ST_W = 3'd5, ST_H = 3'd6;

  localparam logic [6:0] ADDI = 7'b0010011, SW  = 7'b0100011, LW  = 7'b0000011;
  localparam logic [6:0] BR   = 7'b1100011, JAL = 7'b1101111, SYS = 7'b1110011;
  localparam logic [6:0] BAD  = 7'b0000000;

  // expected strobe bits: {pc_en, pc_load, ir_load, reg_we, mem_req, mem_we, halted, illegal}
  localparam logic [7:0] O_PCEN = 8'h80, O_PCLD = 8'h40, O_IR  = 8'h20, O_WE  = 8'h10;
  localparam logic [7:0] O_MREQ = 8'h08, O_MWE  = 8'h04, O_HLT = 8'h02, O_ILL = 8'h01;

  typedef struct {
    logic       start;
    logic [6:0] op;
    logic       bc;
    logic       mr;
    logic [2:0] st;
    logic [7:0] outs;
    logic [7:0] cnt;
  } row_t;

  logic       clk, rst, start, branch_cond, mem_ready;
  logic [6:0] opcode;
  logic       pc_en, pc_load, ir_load, reg_we, mem_req, mem_we, halted, illegal;
  logic [7:0] retired_cnt;
  logic       s_pc_en, s_pc_load, s_ir_load, s_reg_we, s_mem_req, s_mem_we, s_halted, s_illegal;
  logic [1:0] s_retired_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  row_t rows[$];

  cpu_ctrl_fsm #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .branch_cond(branch_cond), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_load(pc_load), .ir_load(ir_load), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .illegal(illegal),
    .retired_cnt(retired_cnt)
  );

  cpu_ctrl_fsm #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .branch_cond(branch_cond), .mem_ready(mem_ready),
    .pc_en(s_pc_en), .pc_load(s_pc_load), .ir_load(s_ir_load), .reg_we(s_reg_we),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .halted(s_halted), .illegal(s_illegal),
    .retired_cnt(s_retired_cnt)
  );

  logic [7:0] got_o;
  logic [2:0] got_st;
  assign got_o  = {pc_en, pc_load, ir_load, reg_we, mem_req, mem_we, halted, illegal};
  assign got_st = dut.r_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic s, input logic [6:0] op, input logic bc, input logic mr,
                     input logic [2:0] st, input logic [7:0] outs, input logic [7:0] cnt);
    row_t r;
    r.start = s; r.op = op; r.bc = bc; r.mr = mr; r.st = st; r.outs = outs; r.cnt = cnt;
    rows.push_back(r);
  endtask

  // each row: drive inputs after the falling edge, compare {state, strobes, count} 1ns later
  task automatic run_rows(input string name);
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      start = rows[i].start; opcode = rows[i].op;
      branch_cond = rows[i].bc; mem_ready = rows[i].mr;
      #1;
      check($sformatf("%s_row%0d {st,outs,cnt}", name, i),
            {8'h0, 5'h0, got_st, got_o, retired_cnt},
            {8'h0, 5'h0, rows[i].st, rows[i].outs, rows[i].cnt});
    end
    rows.delete();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; opcode = ADDI; branch_cond = 1'b0; mem_ready = 1'b0;
    #1;
    check({name, " reset {st,outs,cnt,cnt_sat}"},
          {8'h0, 3'h0, got_st, got_o, retired_cnt, s_retired_cnt},
          {8'h0, 3'h0, ST_I, 8'h00, 8'h00, 2'b00});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = ADDI; branch_cond = 1'b0; mem_ready = 1'b0;

    // ADDI -> SW (ready 3 cycles late) -> LW -> SYSTEM
    do_reset("seq");
    add(1, ADDI, 0, 0, ST_I, 8'h00,          0);
    add(0, ADDI, 0, 0, ST_F, O_IR,           0);
    add(0, ADDI, 0, 0, ST_D, 8'h00,          0);
    add(0, ADDI, 0, 0, ST_E, 8'h00,          0);
    add(0, ADDI, 0, 0, ST_W, O_PCEN | O_WE,  0);
    add(0, SW,   0, 1, ST_F, O_IR,           1);
    add(0, SW,   0, 0, ST_D, 8'h00,          1);
    add(0, SW,   0, 0, ST_E, 8'h00,          1);
    add(0, SW,   0, 0, ST_M, O_MREQ | O_MWE, 1);
    add(0, SW,   0, 0, ST_M, O_MREQ | O_MWE, 1);
    add(0, SW,   0, 0, ST_M, O_MREQ | O_MWE, 1);
    add(0, SW,   0, 1, ST_M, O_PCEN | O_MREQ | O_MWE, 1);
    add(0, LW,   0, 0, ST_F, O_IR,           2);
    add(0, LW,   0, 0, ST_D, 8'h00,          2);
    add(0, LW,   0, 0, ST_E, 8'h00,          2);
    add(0, LW,   0, 1, ST_M, O_MREQ,         2);
    add(0, LW,   0, 0, ST_W, O_PCEN | O_WE,  2);
    add(0, SYS,  0, 0, ST_F, O_IR,           3);
    add(0, SYS,  0, 0, ST_D, 8'h00,          3);
    add(1, SYS,  0, 1, ST_H, O_HLT,          3);
    add(1, LW,   0, 1, ST_H, O_HLT,          3);
    run_rows("seq");

    // taken branch, not-taken branch, JAL, then into a store's MEM wait
    do_reset("br");
    add(1, BR,  0, 0, ST_I, 8'h00,                  0);
    add(0, BR,  0, 0, ST_F, O_IR,                   0);
    add(0, BR,  0, 0, ST_D, 8'h00,                  0);
    add(0, BR,  1, 0, ST_E, O_PCEN | O_PCLD,        0);
    add(0, BR,  0, 0, ST_F, O_IR,                   1);
    add(0, BR,  0, 0, ST_D, 8'h00,                  1);
    add(0, BR,  0, 0, ST_E, O_PCEN,                 1);
    add(0, JAL, 0, 0, ST_F, O_IR,                   2);
    add(0, JAL, 0, 0, ST_D, 8'h00,                  2);
    add(0, JAL, 0, 0, ST_E, O_PCEN | O_PCLD | O_WE, 2);
    add(0, SW,  0, 0, ST_F, O_IR,                   3);
    add(0, SW,  0, 0, ST_D, 8'h00,                  3);
    add(0, SW,  0, 0, ST_E, 8'h00,                  3);
    add(0, SW,  0, 0, ST_M, O_MREQ | O_MWE,         3);
    run_rows("br");

    // reset between edges while waiting in MEM
    #1 rst = 1'b1;
    #1;
    check("async_rst mem_req", {31'h0, mem_req}, 32'h0);
    check("async_rst {st,cnt,halted,illegal}",
          {19'h0, got_st, retired_cnt, halted, illegal}, {19'h0, ST_I, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // illegal opcode halts with sticky flag; start ignored afterwards
    do_reset("ill");
    add(1, BAD,  0, 0, ST_I, 8'h00,         0);
    add(0, BAD,  0, 0, ST_F, O_IR,          0);
    add(0, BAD,  0, 0, ST_D, 8'h00,         0);
    add(1, BAD,  0, 1, ST_H, O_HLT | O_ILL, 0);
    add(1, ADDI, 1, 1, ST_H, O_HLT | O_ILL, 0);
    run_rows("ill");

    // five ADDIs: 8-bit counter reaches 5, 2-bit counter sticks at 3
    do_reset("sat");
    add(1, ADDI, 0, 0, ST_I, 8'h00, 0);
    for (int k = 0; k < 5; k++) begin
      add(0, ADDI, 0, 0, ST_F, O_IR,          8'(k));
      add(0, ADDI, 0, 0, ST_D, 8'h00,         8'(k));
      add(0, ADDI, 0, 0, ST_E, 8'h00,         8'(k));
      add(0, ADDI, 0, 0, ST_W, O_PCEN | O_WE, 8'(k));
    end
    add(0, ADDI, 0, 0, ST_F, O_IR, 5);
    run_rows("sat");
    check("sat cnt_w2", {30'h0, s_retired_cnt}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the retired-instruction counter width.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  SHALL leave IDLE when high.
REQ-005 opcode  input  7  RISC-V opcode field from the instruction register, stable from DECODE until the instruction completes.
REQ-006 branch_cond  input  1  branch comparison result, valid in EXEC.
REQ-007 mem_ready  input  1  data-memory completion strobe.
REQ-008 pc_en  output  1  SHALL let the PC register take its next value this cycle.
REQ-009 pc_load  output  1  SHALL select alu_out (1) or pc_plus4 (0) as the next PC; meaningful only with pc_en.
REQ-010 ir_load / reg_we / mem_req / mem_we  output  1 each  SHALL mean instruction-register load, register-file write, memory request, and store qualifier respectively.
REQ-011 halted  output  1  SHALL be high in HALT.
REQ-012 illegal  output  1  SHALL be a sticky flag for an undecodable opcode.
REQ-013 retired_cnt  output  CNT_W  SHALL count completed instructions.

Function
REQ-014 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT; outputs SHALL be combinational from the state plus branch_cond and mem_ready.
REQ-015 IDLE: all strobes 0; start=1 SHALL move to FETCH, otherwise IDLE holds.
REQ-016 FETCH: ir_load=1 for exactly one cycle; next state SHALL be DECODE.
REQ-017 DECODE: SYSTEM (1110011) SHALL go to HALT; an opcode outside {LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, LUI 0110111, BRANCH 1100011, JAL 1101111, JALR 1100111} SHALL set illegal and go to HALT; any other opcode SHALL go to EXEC.
REQ-018 EXEC, OP/OP-IMM/LUI: no strobes; next state SHALL be WB.
REQ-019 EXEC, LOAD/STORE: next state SHALL be MEM.
REQ-020 EXEC, BRANCH: pc_en=1 and pc_load=branch_cond; next state SHALL be FETCH.
REQ-021 EXEC, JAL/JALR: reg_we=1, pc_en=1, pc_load=1; next state SHALL be FETCH.
REQ-022 MEM: mem_req=1 and mem_we=(opcode==STORE), held until mem_ready=1; wait length is unbounded.
REQ-023 MEM exit on mem_ready: STORE SHALL assert pc_en=1, pc_load=0 in that cycle and go to FETCH; LOAD SHALL go to WB.
REQ-024 WB: reg_we=1, pc_en=1, pc_load=0; next state SHALL be FETCH.
REQ-025 pc_en SHALL pulse exactly once per completed instruction, and never in IDLE, FETCH, DECODE or HALT.
REQ-026 retired_cnt SHALL increment in every cycle with pc_en=1 and saturate at all-ones.
REQ-027 HALT SHALL be absorbing until rst; start, mem_ready and opcode are ignored there, and all strobes are 0.
REQ-028 mem_ready outside MEM SHALL be ignored.

Reset
REQ-029 rst SHALL force the state to IDLE immediately, independent of clk, including mid-MEM; mem_req SHALL drop asynchronously.
REQ-030 In reset, all strobes, halted and illegal SHALL be 0 and retired_cnt SHALL be 0.

Structure
REQ-031 Package cpu_ctrl_pkg SHALL hold the state enum and the opcode constants.
REQ-032 The saturating retire counter SHALL be a sub-module named sat_counter; the state register SHALL use the team's standard DFF macro with reset value IDLE.

Verification
REQ-033 Sequence ADDI (0010011) -> SW (0100011) with mem_ready 3 cycles late -> LW -> SYSTEM: the bench SHALL see states F,D,E,W,F,D,E,M×4,F,D,E,M,W,F,D,HALT and retired_cnt=3.
REQ-034 BRANCH with branch_cond=1, then BRANCH with branch_cond=0: the bench SHALL see pc_en=1 with pc_load=1, then pc_en=1 with pc_load=0, both in EXEC.
REQ-035 JAL: the EXEC cycle SHALL show reg_we=1, pc_en=1 and pc_load=1.
REQ-036 opcode=0000000 in DECODE: illegal=1, halted=1; a later start=1 SHALL leave the state unchanged.
REQ-037 rst asserted mid-MEM between clock edges: mem_req SHALL fall before the next edge, with state IDLE and retired_cnt=0.
REQ-038 With CNT_W=2, five ADDI instructions: retired_cnt SHALL saturate at 3.
